tile_seq_ctrl: RTL and testbench
================================

# tile_seq_ctrl

Parametrised tile sequencer for the systolic matrix-multiply datapath. It walks a runtime-configured grid of N×N output tiles and issues B-tile loads and compute starts. It waits for C-gather completion on each tile and pulses `done` when the job ends. Compared with the previous single-buffer controller it adds:
- runtime tile counts and a selectable loop order;
- optional ping-pong B prefetch that overlaps the next load with the current compute;
- abort, error flagging and tile-index outputs for the address generators.

## Interface
Parameters:
- `N`, 16: systolic array edge (informational; tile size).
- `RT_W`, 4: width of row-tile count/index (up to 2^RT_W row tiles).
- `CT_W`, 4: width of col-tile count/index (up to 2^CT_W col tiles).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  job start; sampled only in IDLE.
- `cfg_rows_m1`  in  RT_W  row tiles minus 1; latched at accepted start.
- `cfg_cols_m1`  in  CT_W  col tiles minus 1; latched at accepted start.
- `cfg_col_inner`  in  1  0: row index inner loop; 1: col index inner loop. Latched at start.
- `cfg_prefetch`  in  1  1: enable ping-pong prefetch. Latched at start.
- `abort`  in  1  terminate job.
- `b_load`  out  1  one-cycle load request.
- `b_buf_sel`  out  1  destination buffer of the current/last `b_load`.
- `ld_row_idx`, `ld_col_idx`  out  RT_W/CT_W  tile being loaded; valid with `b_load`, held until the next `b_load`.
- `b_load_done`  in  1  one-cycle load completion.
- `start_cal`  out  1  one-cycle compute start.
- `cal_buf_sel`  out  1  buffer consumed by the current compute.
- `row_idx`, `col_idx`  out  RT_W/CT_W  tile currently computing.
- `c_gather_done`  in  1  one-cycle completion of current tile.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse, job finished normally.
- `err`  out  1  one-cycle pulse, protocol violation.

## Operation
State machine and transitions:
- **IDLE** → on `start`:
  - latch cfg;
  - load index = (0,0);
  - pulse `b_load`, `b_buf_sel`=0;
  - go to LOAD.
- **LOAD** → on `b_load_done`:
  - pulse `start_cal`; `cal_buf_sel` = `b_buf_sel`; `row_idx`/`col_idx` = load index;
  - if prefetch is enabled and the tile is not last: in the same cycle pulse `b_load` for the next tile into the other buffer and set `pf_pend`;
  - go to COMPUTE.
- **COMPUTE** → on `c_gather_done`:
  - if the tile is last (`row_idx`=`cfg_rows_m1` and `col_idx`=`cfg_cols_m1`): pulse `done`, go to IDLE.
  - else, no prefetch: pulse `b_load` for the next tile into the same buffer (0), go to LOAD.
  - else, prefetch already complete (`pf_pend`=0): pulse `start_cal` on the other buffer, advance the compute index, issue the next prefetch if one remains, stay in COMPUTE.
  - else (prefetch still pending): go to WAIT_PF.
- **WAIT_PF** → on `b_load_done`: same action as COMPUTE's "prefetch complete" path, then go to COMPUTE.

Loop order and index rules:
- Inner index wraps from its max to 0 and increments the outer index.
- Default (`cfg_col_inner`=0) matches the legacy order: all rows of col 0, then col 1, and so on.
- Buffers toggle on every load when prefetch=1. Buffer is always 0 when prefetch=0.

Simultaneous and out-of-protocol events:
- `b_load_done` in COMPUTE clears `pf_pend`.
- `b_load_done` and `c_gather_done` in the same cycle are treated as prefetch complete (no WAIT_PF visit).
- `err` pulses for:
  - `b_load_done` with no load outstanding;
  - `c_gather_done` outside COMPUTE.
  
  The event is otherwise ignored and the state is unchanged.
- `start` while `busy` is ignored and raises no error.
- `abort` (any state) → IDLE next cycle: no `done`, `pf_pend` cleared, no further pulses. A later `b_load_done` while IDLE pulses `err`. `abort` beats any simultaneous event.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, all pulses=0, `busy`=0, all indices=0, both buffer selects=0, `pf_pend`=0.
- Latencies:
  - `b_load` asserts the cycle after `start`.
  - `start_cal` asserts the cycle after `b_load_done` (LOAD/WAIT_PF) or after `c_gather_done` (COMPUTE fast path).
  - `done` asserts the cycle after the final `c_gather_done`; `busy` drops that same cycle.
- Back-to-back jobs: `start` is accepted the cycle after `done`.
- Reset mid-job: outputs return to reset values the next cycle; in-flight handshakes are forgotten.
- Single tile (`cfg_rows_m1`=`cfg_cols_m1`=0): exactly one `b_load`, one `start_cal`, one `done`; no prefetch is issued.

## Test plan
- **Legacy order, 2×2, prefetch=0, col_inner=0:**
  - Expected compute order (r,c): (0,0), (1,0), (0,1), (1,1).
  - 4 `b_load` pulses, all `b_buf_sel`=0.
  - `done` 1 cycle after the 4th `c_gather_done`.
- **1×1 job:** `start` → `b_load` at +1; `b_load_done` → `start_cal` at +1; `c_gather_done` → `done` at +1. No second `b_load`.
- **Prefetch 2×3, col_inner=1:**
  - Expected order: (0,0), (0,1), (0,2), (1,0), (1,1), (1,2).
  - `b_buf_sel` alternates 0,1,0,…; each `cal_buf_sel` matches its load.
  - Mix of early and late `b_load_done`: WAIT_PF is entered only when late.
- **Simultaneous events:** `b_load_done` and `c_gather_done` in the same cycle in COMPUTE → `start_cal` next cycle, no WAIT_PF.
- **Abort and reset:**
  - `abort` in WAIT_PF → `busy`=0 next cycle, no `done`; a subsequent `b_load_done` gives `err`=1 for one cycle.
  - `rst` mid-COMPUTE → all outputs at reset values.
- **Protocol errors:**
  - `c_gather_done` in LOAD → `err` pulse, state stays LOAD.
  - `start` while busy → ignored, config unchanged.

Source files
------------

// File: rtl/tile_seq_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tile_seq_ctrl_if : job/config, B-load and compute handshakes of the      |
// |                    systolic tile sequencer.            Revision: 1.0      |
// +--------------------------------------------------------------------------+
interface tile_seq_ctrl_if #(
   parameter int RT_W = 4,
   parameter int CT_W = 4
);
   logic            start;
   logic [RT_W-1:0] cfg_rows_m1;
   logic [CT_W-1:0] cfg_cols_m1;
   logic            cfg_col_inner;
   logic            cfg_prefetch;
   logic            abort;
   logic            b_load;
   logic            b_buf_sel;
   logic [RT_W-1:0] ld_row_idx;
   logic [CT_W-1:0] ld_col_idx;
   logic            b_load_done;
   logic            start_cal;
   logic            cal_buf_sel;
   logic [RT_W-1:0] row_idx;
   logic [CT_W-1:0] col_idx;
   logic            c_gather_done;
   logic            busy;
   logic            done;
   logic            err;

   // The sequencer sits on the slave side; the host/datapath drives the master side.
   modport slave (
      input  start, cfg_rows_m1, cfg_cols_m1, cfg_col_inner, cfg_prefetch, abort,
             b_load_done, c_gather_done,
      output b_load, b_buf_sel, ld_row_idx, ld_col_idx, start_cal, cal_buf_sel,
             row_idx, col_idx, busy, done, err
   );
   modport master (
      output start, cfg_rows_m1, cfg_cols_m1, cfg_col_inner, cfg_prefetch, abort,
             b_load_done, c_gather_done,
      input  b_load, b_buf_sel, ld_row_idx, ld_col_idx, start_cal, cal_buf_sel,
             row_idx, col_idx, busy, done, err
   );
endinterface
`default_nettype wire

// File: rtl/tile_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tile_seq_ctrl : walks the output-tile grid, issuing B loads (optionally  |
// |                 ping-pong prefetched) and compute starts.  Revision: 1.0 |
// +--------------------------------------------------------------------------+
module tile_seq_ctrl #(
   parameter int N    = 16,
   parameter int RT_W = 4,
   parameter int CT_W = 4
) (
   input  logic           clk,
   input  logic           rst,
   tile_seq_ctrl_if.slave bus
);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LOAD    = 2'd1;
   localparam logic [1:0] S_COMPUTE = 2'd2;
   localparam logic [1:0] S_WAIT_PF = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [RT_W-1:0] rows_m1_q, rows_m1_d, ld_row_q, ld_row_d, row_q, row_d;
   logic [CT_W-1:0] cols_m1_q, cols_m1_d, ld_col_q, ld_col_d, col_q, col_d;
   logic            col_inner_q, col_inner_d, prefetch_q, prefetch_d;
   logic            b_load_q, b_load_d, b_buf_q, b_buf_d;
   logic            start_cal_q, start_cal_d, cal_buf_q, cal_buf_d;
   logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic            pf_pend_q, pf_pend_d;

   // N only sizes the datapath; it is carried here for elaboration symmetry.
   logic unused_n;
   assign unused_n = ^N;

   function automatic logic [RT_W+CT_W-1:0] next_tile(
      input logic [RT_W-1:0] r, input logic [CT_W-1:0] c,
      input logic [RT_W-1:0] r_m1, input logic [CT_W-1:0] c_m1, input logic col_inner);
      logic [RT_W-1:0] nr;
      logic [CT_W-1:0] nc;
      nr = r;
      nc = c;
      if (col_inner) begin
         if (c == c_m1) begin nc = '0; nr = r + 1'b1; end
         else           nc = c + 1'b1;
      end else begin
         if (r == r_m1) begin nr = '0; nc = c + 1'b1; end
         else           nr = r + 1'b1;
      end
      return {nr, nc};
   endfunction

   logic [RT_W-1:0] ld_nxt_row, cal_nxt_row;
   logic [CT_W-1:0] ld_nxt_col, cal_nxt_col;
   logic            ld_last, cal_last, load_out, pf_ready, advance;

   assign {ld_nxt_row, ld_nxt_col}   = next_tile(ld_row_q, ld_col_q, rows_m1_q, cols_m1_q, col_inner_q);
   assign {cal_nxt_row, cal_nxt_col} = next_tile(row_q, col_q, rows_m1_q, cols_m1_q, col_inner_q);
   assign ld_last  = (ld_row_q == rows_m1_q) && (ld_col_q == cols_m1_q);
   assign cal_last = (row_q == rows_m1_q) && (col_q == cols_m1_q);
   assign load_out = (state_q == S_LOAD) || (state_q == S_WAIT_PF) ||
                     ((state_q == S_COMPUTE) && pf_pend_q);
   assign pf_ready = !pf_pend_q || bus.b_load_done;
   // Swap to the prefetched buffer: either a fast-path gather or a late prefetch landing.
   assign advance  = ((state_q == S_COMPUTE) && bus.c_gather_done && !cal_last &&
                      prefetch_q && pf_ready) ||
                     ((state_q == S_WAIT_PF) && bus.b_load_done);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rows_m1_q   <= '0;
         cols_m1_q   <= '0;
         col_inner_q <= 1'b0;
         prefetch_q  <= 1'b0;
         ld_row_q    <= '0;
         ld_col_q    <= '0;
         row_q       <= '0;
         col_q       <= '0;
         b_load_q    <= 1'b0;
         b_buf_q     <= 1'b0;
         start_cal_q <= 1'b0;
         cal_buf_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         pf_pend_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rows_m1_q   <= rows_m1_d;
         cols_m1_q   <= cols_m1_d;
         col_inner_q <= col_inner_d;
         prefetch_q  <= prefetch_d;
         ld_row_q    <= ld_row_d;
         ld_col_q    <= ld_col_d;
         row_q       <= row_d;
         col_q       <= col_d;
         b_load_q    <= b_load_d;
         b_buf_q     <= b_buf_d;
         start_cal_q <= start_cal_d;
         cal_buf_q   <= cal_buf_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         pf_pend_q   <= pf_pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:    if (bus.start) state_d = S_LOAD;
            S_LOAD:    if (bus.b_load_done) state_d = S_COMPUTE;
            S_COMPUTE: begin
               if (bus.c_gather_done) begin
                  if (cal_last)        state_d = S_IDLE;
                  else if (!prefetch_q) state_d = S_LOAD;
                  else if (pf_ready)   state_d = S_COMPUTE;
                  else                 state_d = S_WAIT_PF;
               end
            end
            S_WAIT_PF: if (bus.b_load_done) state_d = S_COMPUTE;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      rows_m1_d   = rows_m1_q;
      cols_m1_d   = cols_m1_q;
      col_inner_d = col_inner_q;
      prefetch_d  = prefetch_q;
      ld_row_d    = ld_row_q;
      ld_col_d    = ld_col_q;
      row_d       = row_q;
      col_d       = col_q;
      b_buf_d     = b_buf_q;
      cal_buf_d   = cal_buf_q;
      pf_pend_d   = pf_pend_q;
      b_load_d    = 1'b0;
      start_cal_d = 1'b0;
      done_d      = 1'b0;
      busy_d      = (state_d != S_IDLE);
      err_d       = !bus.abort && ((bus.b_load_done && !load_out) ||
                                   (bus.c_gather_done && (state_q != S_COMPUTE)));
      if (bus.abort) begin
         pf_pend_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  rows_m1_d   = bus.cfg_rows_m1;
                  cols_m1_d   = bus.cfg_cols_m1;
                  col_inner_d = bus.cfg_col_inner;
                  prefetch_d  = bus.cfg_prefetch;
                  ld_row_d    = '0;
                  ld_col_d    = '0;
                  b_buf_d     = 1'b0;
                  b_load_d    = 1'b1;
               end
            end
            S_LOAD: begin
               if (bus.b_load_done) begin
                  start_cal_d = 1'b1;
                  cal_buf_d   = b_buf_q;
                  row_d       = ld_row_q;
                  col_d       = ld_col_q;
                  if (prefetch_q && !ld_last) begin
                     b_load_d  = 1'b1;
                     ld_row_d  = ld_nxt_row;
                     ld_col_d  = ld_nxt_col;
                     b_buf_d   = !b_buf_q;
                     pf_pend_d = 1'b1;
                  end
               end
            end
            S_COMPUTE: begin
               if (bus.b_load_done) pf_pend_d = 1'b0;
               if (bus.c_gather_done) begin
                  if (cal_last) begin
                     done_d = 1'b1;
                  end else if (!prefetch_q) begin
                     b_load_d = 1'b1;
                     ld_row_d = cal_nxt_row;
                     ld_col_d = cal_nxt_col;
                     b_buf_d  = 1'b0;
                  end
               end
            end
            default: ;
         endcase
         if (advance) begin
            start_cal_d = 1'b1;
            cal_buf_d   = b_buf_q;
            row_d       = ld_row_q;
            col_d       = ld_col_q;
            pf_pend_d   = 1'b0;
            if (!ld_last) begin
               b_load_d  = 1'b1;
               ld_row_d  = ld_nxt_row;
               ld_col_d  = ld_nxt_col;
               b_buf_d   = !b_buf_q;
               pf_pend_d = 1'b1;
            end
         end
      end
   end

   assign bus.b_load      = b_load_q;
   assign bus.b_buf_sel   = b_buf_q;
   assign bus.ld_row_idx  = ld_row_q;
   assign bus.ld_col_idx  = ld_col_q;
   assign bus.start_cal   = start_cal_q;
   assign bus.cal_buf_sel = cal_buf_q;
   assign bus.row_idx     = row_q;
   assign bus.col_idx     = col_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.err         = err_q;
endmodule
`default_nettype wire

// File: tb/tb_tile_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tile_seq_ctrl : directed self-checking bench for tile_seq_ctrl.       |
// |                                                       Revision: 1.0      |
// +--------------------------------------------------------------------------+
module tb_tile_seq_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   n_bload = 0;
   int   nb0;
   int   er[4] = '{0, 1, 0, 1};
   int   ec[4] = '{0, 0, 1, 1};

   tile_seq_ctrl_if #(.RT_W(4), .CT_W(4)) bus ();

   tile_seq_ctrl #(.N(16), .RT_W(4), .CT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.b_load === 1'b1) n_bload++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      bus.start = 1'b1; tick(); bus.start = 1'b0;
   endtask
   task automatic pulse_ld();
      bus.b_load_done = 1'b1; tick(); bus.b_load_done = 1'b0;
   endtask
   task automatic pulse_cg();
      bus.c_gather_done = 1'b1; tick(); bus.c_gather_done = 1'b0;
   endtask
   task automatic pulse_both();
      bus.b_load_done = 1'b1; bus.c_gather_done = 1'b1; tick();
      bus.b_load_done = 1'b0; bus.c_gather_done = 1'b0;
   endtask
   task automatic pulse_abort();
      bus.abort = 1'b1; tick(); bus.abort = 1'b0;
   endtask
   task automatic cfg(input int rm1, input int cm1, input bit ci, input bit pf);
      bus.cfg_rows_m1 = 4'(rm1); bus.cfg_cols_m1 = 4'(cm1);
      bus.cfg_col_inner = ci;    bus.cfg_prefetch = pf;
   endtask
   task automatic chk_load(input string tag, input int r, input int c, input int b);
      check({tag, "_bload"}, int'(bus.b_load), 1);
      check({tag, "_ldrow"}, int'(bus.ld_row_idx), r);
      check({tag, "_ldcol"}, int'(bus.ld_col_idx), c);
      check({tag, "_bbuf"},  int'(bus.b_buf_sel), b);
   endtask
   task automatic chk_cal(input string tag, input int r, input int c, input int b);
      check({tag, "_scal"}, int'(bus.start_cal), 1);
      check({tag, "_row"},  int'(bus.row_idx), r);
      check({tag, "_col"},  int'(bus.col_idx), c);
      check({tag, "_cbuf"}, int'(bus.cal_buf_sel), b);
   endtask

   initial begin
      bus.start = 0; bus.abort = 0; bus.b_load_done = 0; bus.c_gather_done = 0;
      cfg(0, 0, 0, 0);
      tick(); tick();
      rst = 1'b0;
      check("rst_busy", int'(bus.busy), 0);
      check("rst_bload", int'(bus.b_load), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_err", int'(bus.err), 0);
      check("rst_idx", int'({bus.row_idx, bus.col_idx, bus.ld_row_idx, bus.ld_col_idx}), 0);

      // Legacy order 2x2, no prefetch
      cfg(1, 1, 0, 0);
      nb0 = n_bload;
      pulse_start();
      chk_load("t1_first", 0, 0, 0);
      check("t1_busy", int'(bus.busy), 1);
      for (int k = 0; k < 4; k++) begin
         pulse_ld();
         chk_cal($sformatf("t1_cal%0d", k), er[k], ec[k], 0);
         tick();
         check("t1_scal_low", int'(bus.start_cal), 0);
         pulse_cg();
         if (k < 3) chk_load($sformatf("t1_ld%0d", k + 1), er[k + 1], ec[k + 1], 0);
         else begin
            check("t1_done", int'(bus.done), 1);
            check("t1_busy_drop", int'(bus.busy), 0);
         end
      end
      tick();
      check("t1_done_once", int'(bus.done), 0);
      check("t1_nload", n_bload - nb0, 4);

      // 1x1 job with prefetch requested: none may be issued
      cfg(0, 0, 0, 1);
      nb0 = n_bload;
      pulse_start();
      chk_load("t2", 0, 0, 0);
      tick();
      check("t2_bload_pulse", int'(bus.b_load), 0);
      pulse_ld();
      chk_cal("t2", 0, 0, 0);
      check("t2_no_pf", int'(bus.b_load), 0);
      tick();
      pulse_cg();
      check("t2_done", int'(bus.done), 1);
      check("t2_nload", n_bload - nb0, 1);

      // Back-to-back: prefetch 2x3, col inner, start in the done cycle
      cfg(1, 2, 1, 1);
      pulse_start();
      chk_load("t3_l0", 0, 0, 0);
      pulse_ld();
      chk_cal("t3_c0", 0, 0, 0);
      chk_load("t3_l1", 0, 1, 1);
      pulse_ld();
      check("t3_early_err", int'(bus.err), 0);
      check("t3_early_scal", int'(bus.start_cal), 0);
      pulse_cg();
      chk_cal("t3_c1", 0, 1, 1);
      chk_load("t3_l2", 0, 2, 0);
      pulse_cg();
      check("t3_wait_scal", int'(bus.start_cal), 0);
      check("t3_wait_busy", int'(bus.busy), 1);
      tick();
      pulse_ld();
      chk_cal("t3_c2", 0, 2, 0);
      chk_load("t3_l3", 1, 0, 1);
      pulse_both();
      chk_cal("t3_c3", 1, 0, 1);
      chk_load("t3_l4", 1, 1, 0);
      check("t3_both_err", int'(bus.err), 0);
      pulse_ld();
      pulse_cg();
      chk_cal("t3_c4", 1, 1, 0);
      chk_load("t3_l5", 1, 2, 1);
      pulse_ld();
      pulse_cg();
      chk_cal("t3_c5", 1, 2, 1);
      check("t3_no_more_load", int'(bus.b_load), 0);
      pulse_cg();
      check("t3_done", int'(bus.done), 1);
      check("t3_busy_drop", int'(bus.busy), 0);
      tick();

      // Protocol errors and start while busy
      cfg(1, 1, 0, 0);
      pulse_start();
      pulse_cg();
      check("t4_cg_in_load_err", int'(bus.err), 1);
      tick();
      check("t4_err_once", int'(bus.err), 0);
      pulse_ld();
      chk_cal("t4_still_load", 0, 0, 0);
      cfg(0, 0, 1, 0);
      pulse_start();
      check("t4_busy_start_err", int'(bus.err), 0);
      check("t4_busy_start_load", int'(bus.b_load), 0);
      pulse_ld();
      check("t4_spurious_ld_err", int'(bus.err), 1);
      pulse_cg();
      chk_load("t4_cfg_kept", 1, 0, 0);
      check("t4_no_done", int'(bus.done), 0);
      pulse_abort();
      check("t4_abort_busy", int'(bus.busy), 0);

      // Abort in WAIT_PF
      cfg(0, 1, 0, 1);
      pulse_start();
      pulse_ld();
      chk_load("t5_pf", 0, 1, 1);
      pulse_cg();
      check("t5_wait_scal", int'(bus.start_cal), 0);
      pulse_abort();
      check("t5_busy", int'(bus.busy), 0);
      check("t5_done", int'(bus.done), 0);
      check("t5_bload", int'(bus.b_load), 0);
      pulse_ld();
      check("t5_late_ld_err", int'(bus.err), 1);
      tick();
      check("t5_err_once", int'(bus.err), 0);

      // Reset mid-COMPUTE
      cfg(1, 1, 0, 1);
      pulse_start();
      pulse_ld();
      chk_load("t6_pf", 1, 0, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_busy", int'(bus.busy), 0);
      check("t6_pulses", int'({bus.b_load, bus.start_cal, bus.done, bus.err}), 0);
      check("t6_idx", int'({bus.row_idx, bus.col_idx, bus.ld_row_idx, bus.ld_col_idx}), 0);
      check("t6_bufs", int'({bus.b_buf_sel, bus.cal_buf_sel}), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
